// File: rtl/rmii_transmitter.sv
// RMII transmit framer: preamble/SFD, payload with zero padding, CRC-32 FCS and
// inter-frame gap, streamed out one dibit per 50 MHz clock.
module rmii_transmitter #(
    parameter int unsigned MIN_FRAME = 60,
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic        clk_50_mhz,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic        tx_en,
    output logic [1:0]  tx_d,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_count
);

    localparam logic [15:0] MinFrame = 16'(MIN_FRAME);
    localparam logic [15:0] IfgLast  = 16'(IFG_BYTES * 4 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  dibit_q, dibit_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        last_q, last_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        tx_en_q, tx_en_d;
    logic [1:0]  tx_d_q, tx_d_d;
    logic        underrun_q, underrun_d;
    logic [31:0] crc_upd;
    logic        byte_end;

    // Reflected CRC-32 advanced by one dibit, bit 0 first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign tx_ready = (dibit_q == 2'd3) &&
                      ((state_q == StSfd) || ((state_q == StData) && !last_q));
    assign busy        = (state_q != StIdle);
    assign tx_en       = tx_en_q;
    assign tx_d        = tx_d_q;
    assign underrun    = underrun_q;
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        dibit_d       = dibit_q;
        idx_d         = idx_q;
        sh_d          = sh_q;
        crc_d         = crc_q;
        byte_cnt_d    = byte_cnt_q;
        last_d        = last_q;
        gap_d         = gap_q;
        frame_count_d = frame_count_q;
        underrun_d    = 1'b0;
        crc_upd       = crc_dibit(crc_q, sh_q[1:0]);
        byte_end      = (dibit_q == 2'd3);

        // sh_q[1:0] is always the dibit currently on the wire.
        if (state_q != StIdle && state_q != StIfg) begin
            dibit_d = dibit_q + 2'd1;
            sh_d    = sh_q >> 2;
        end

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d    = StPreamble;
                    dibit_d    = 2'd0;
                    idx_d      = 3'd0;
                    sh_d       = 32'h55;
                    crc_d      = 32'hFFFF_FFFF;
                    byte_cnt_d = 16'd0;
                end
            end
            StPreamble: begin
                if (byte_end) begin
                    if (idx_q == 3'd6) begin
                        state_d = StSfd;
                        sh_d    = 32'hD5;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = 32'h55;
                    end
                end
            end
            StSfd, StData: begin
                if (state_q == StData) begin
                    crc_d = crc_upd;
                end
                if (byte_end) begin
                    if (state_q == StData && last_q) begin
                        if (byte_cnt_q < MinFrame) begin
                            state_d    = StPad;
                            sh_d       = 32'h0;
                            byte_cnt_d = byte_cnt_q + 16'd1;
                        end else begin
                            state_d = StFcs;
                            sh_d    = ~crc_upd;
                            idx_d   = 3'd0;
                        end
                    end else if (tx_valid) begin
                        state_d    = StData;
                        sh_d       = {24'h0, tx_data};
                        last_d     = tx_last;
                        byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                    end else begin
                        state_d    = StIfg;
                        gap_d      = 16'd0;
                        underrun_d = 1'b1;
                    end
                end
            end
            StPad: begin
                crc_d = crc_upd;
                if (byte_end) begin
                    if (byte_cnt_q >= MinFrame) begin
                        state_d = StFcs;
                        sh_d    = ~crc_upd;
                        idx_d   = 3'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end
            end
            StFcs: begin
                if (byte_end) begin
                    if (idx_q == 3'd3) begin
                        state_d       = StIfg;
                        gap_d         = 16'd0;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StIfg: begin
                if (gap_q >= IfgLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        tx_en_d = (state_d != StIdle) && (state_d != StIfg);
        tx_d_d  = tx_en_d ? sh_d[1:0] : 2'b00;
    end

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            dibit_q       <= 2'd0;
            idx_q         <= 3'd0;
            sh_q          <= 32'h0;
            crc_q         <= 32'hFFFF_FFFF;
            byte_cnt_q    <= 16'd0;
            last_q        <= 1'b0;
            gap_q         <= 16'd0;
            frame_count_q <= 16'd0;
            tx_en_q       <= 1'b0;
            tx_d_q        <= 2'b00;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            dibit_q       <= dibit_d;
            idx_q         <= idx_d;
            sh_q          <= sh_d;
            crc_q         <= crc_d;
            byte_cnt_q    <= byte_cnt_d;
            last_q        <= last_d;
            gap_q         <= gap_d;
            frame_count_q <= frame_count_d;
            tx_en_q       <= tx_en_d;
            tx_d_q        <= tx_d_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule
